// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V IF stage owning the PC and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 256,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        pc_src_e,
  input  logic [31:0] pc_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc_plus4_d,
  output logic        valid_d,
  output logic        fault_d
);
  logic [31:0] pc_f_q, pc_f_d, instr_d_q, instr_d_d, pc_d_q, pc_d_d, pc_plus4_d_q, pc_plus4_d_d;
  logic        valid_d_q, valid_d_d, fault_d_q, fault_d_d;
  logic [31:0] pc_plus4_f;
  logic        in_range, bubble;
  always_comb begin
    pc_plus4_f   = pc_f_q + 32'd4;
    in_range     = {2'b00, pc_f_q[31:2]} < 32'(IMEM_WORDS);
    bubble       = flush_d | pc_src_e;
    pc_f_d       = pc_src_e ? {pc_target_e[31:2], 2'b00} : stall_f ? pc_f_q : pc_plus4_f;
    instr_d_d    = bubble ? NOP_INSTR : stall_d ? instr_d_q : in_range ? imem_rdata : NOP_INSTR;
    pc_d_d       = (bubble | ~stall_d) ? pc_f_q : pc_d_q;
    pc_plus4_d_d = (bubble | ~stall_d) ? pc_plus4_f : pc_plus4_d_q;
    valid_d_d    = bubble ? 1'b0 : stall_d ? valid_d_q : 1'b1;
    fault_d_d    = bubble ? 1'b0 : stall_d ? fault_d_q : ~in_range;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_f_q       <= {RESET_PC[31:2], 2'b00};
      instr_d_q    <= NOP_INSTR;
      pc_d_q       <= '0;
      pc_plus4_d_q <= '0;
      valid_d_q    <= 1'b0;
      fault_d_q    <= 1'b0;
    end else begin
      pc_f_q       <= pc_f_d;
      instr_d_q    <= instr_d_d;
      pc_d_q       <= pc_d_d;
      pc_plus4_d_q <= pc_plus4_d_d;
      valid_d_q    <= valid_d_d;
      fault_d_q    <= fault_d_d;
    end
  end
  assign imem_addr  = pc_f_q;
  assign pc_f       = pc_f_q;
  assign instr_d    = instr_d_q;
  assign pc_d       = pc_d_q;
  assign pc_plus4_d = pc_plus4_d_q;
  assign valid_d    = valid_d_q;
  assign fault_d    = fault_d_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench comparing fetch_stage against a behavioural pipeline model.
module tb_fetch_stage;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic        clk = 1'b0, rst, stall_f, stall_d, flush_d, pc_src_e;
  logic [31:0] pc_target_e, imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_plus4_d;
  logic        valid_d, fault_d;
  int          vectors = 0, miscompares = 0;
  typedef struct {
    logic [31:0] pc, instr, pcd, pc4;
    logic        valid, fault;
  } exp_t;
  exp_t q[$];
  exp_t m;
  fetch_stage dut (
    .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
    .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d), .valid_d(valid_d), .fault_d(fault_d)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction
  assign imem_rdata = mem_word(imem_addr);
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_f", pc_f, e.pc);
      chk("imem_addr", imem_addr, e.pc);
      chk("instr_d", instr_d, e.instr);
      chk("pc_d", pc_d, e.pcd);
      chk("pc_plus4_d", pc_plus4_d, e.pc4);
      chk("valid_d", {31'b0, valid_d}, {31'b0, e.valid});
      chk("fault_d", {31'b0, fault_d}, {31'b0, e.fault});
    end
  end
  task automatic step(input logic r, input logic sf, input logic sd, input logic fl,
                      input logic src, input logic [31:0] tgt);
    logic [31:0] next_pc;
    rst = r; stall_f = sf; stall_d = sd; flush_d = fl; pc_src_e = src; pc_target_e = tgt;
    if (!r) begin
      m = '{pc: 32'h0, instr: NOP, pcd: 32'h0, pc4: 32'h0, valid: 1'b0, fault: 1'b0};
    end else begin
      next_pc = src ? (tgt & ~32'd3) : sf ? m.pc : m.pc + 32'd4;
      if (fl || src)
        m = '{pc: next_pc, instr: NOP, pcd: m.pc, pc4: m.pc + 32'd4, valid: 1'b0, fault: 1'b0};
      else if (sd)
        m.pc = next_pc;
      else if ((m.pc >> 2) < 32'd256)
        m = '{pc: next_pc, instr: mem_word(m.pc), pcd: m.pc, pc4: m.pc + 32'd4, valid: 1'b1, fault: 1'b0};
      else
        m = '{pc: next_pc, instr: NOP, pcd: m.pc, pc4: m.pc + 32'd4, valid: 1'b1, fault: 1'b1};
    end
    q.push_back(m);
    @(negedge clk);
  endtask
  initial begin
    logic [31:0] tgt;
    logic        s;
    repeat (3) step(0, 0, 0, 0, 0, 0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    repeat (2) step(1, 1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h40);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 1, 32'h23);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h400);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h0);
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'hFFFF_FFFC);
    repeat (3) step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 0, 1, 32'h10);
    step(0, 1, 1, 1, 1, 32'h80);
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      case ($urandom_range(0, 3))
        0: tgt = $urandom_range(0, 1100);
        1: tgt = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        2: tgt = 32'h3F0 + $urandom_range(0, 31);
        default: tgt = $urandom;
      endcase
      s = ($urandom_range(0, 5) == 0);
      step($urandom_range(0, 60) != 0,
           s ? 1'($urandom) : ($urandom_range(0, 4) == 0),
           s ? 1'($urandom) : ($urandom_range(0, 4) == 0),
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 7) == 0, tgt);
    end
    repeat (2) @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
